// File: rtl/fp_collect_pkg.sv
// Shared types and constants for the float-core result collector.
// Contents: default widths and depths, the tagged result entry,
// and the bit positions of the sticky error flags.
package fp_collect_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TAG_W_DEF   = 4;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned MAX_LAT_DEF = 16;

    // Tagged result as stored in the result FIFO (tag in the upper bits)
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

    // Sticky error flag positions
    localparam int unsigned ERR_N         = 4;
    localparam logic [1:0]  ERR_ISSUE_OVF = 2'd0;
    localparam logic [1:0]  ERR_ORPHAN    = 2'd1;
    localparam logic [1:0]  ERR_RES_OVF   = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT   = 2'd3;

endpackage

// File: rtl/fp_result_collector_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst (sync, active-high); push/din write; pop read;
//        full, empty, count status; head = entry at read pointer (0 when empty).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate stale storage so the head reads 0 after reset or when drained
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally; count is tracked separately to tell full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_result_collector.sv
// Pairs float-core results with the tag recorded at issue time and buffers
// the tagged results behind a valid/ready interface (the core cannot stall).
// Ports: clk, rst (sync, active-high)
//   issue_nd/issue_tag : issue pulse and destination tag; can_issue = tag FIFO not full
//   core_rdy/core_result : core result strobe and data
//   out_valid/out_data/out_tag/out_ready : tagged result stream
//   in_flight : outstanding issues
//   clr_err, issue_ovf, orphan_err, res_ovf, timeout_err : sticky protocol faults
module fp_result_collector
    import fp_collect_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned MAX_LAT = MAX_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_nd,
    input  logic [TAG_W-1:0]       issue_tag,
    output logic                   can_issue,
    input  logic                   core_rdy,
    input  logic [DATA_W-1:0]      core_result,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] in_flight,
    input  logic                   clr_err,
    output logic                   issue_ovf,
    output logic                   orphan_err,
    output logic                   res_ovf,
    output logic                   timeout_err
);

    localparam int unsigned WD_W  = $clog2(MAX_LAT + 1);
    localparam int unsigned RES_W = TAG_W + DATA_W;

    logic                   tag_full;
    logic                   tag_empty;
    logic [TAG_W-1:0]       tag_head;
    logic                   tag_pop;
    logic                   res_push;
    logic                   res_pop;
    logic                   res_full;
    logic                   res_empty;
    logic [RES_W-1:0]       res_din;
    logic [RES_W-1:0]       res_head;
    logic [$clog2(DEPTH):0] res_count_unused;
    logic [WD_W-1:0]        wd;
    logic [WD_W-1:0]        wd_next;
    logic [ERR_N-1:0]       err;
    logic [ERR_N-1:0]       err_set;

    // A rdy only consumes a tag that was already outstanding before this cycle
    assign tag_pop  = core_rdy && !tag_empty;
    assign res_push = tag_pop;
    assign res_din  = {tag_head, core_result};
    assign res_pop  = out_ready && !res_empty;

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_nd),
        .din   (issue_tag),
        .pop   (core_rdy),
        .full  (tag_full),
        .empty (tag_empty),
        .count (in_flight),
        .head  (tag_head)
    );

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (res_din),
        .pop   (res_pop),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count_unused),
        .head  (res_head)
    );

    // Watchdog on the oldest outstanding issue
    always_comb begin
        wd_next = wd;
        if (tag_pop || tag_empty) begin
            wd_next = '0;
        end else if (wd != WD_W'(MAX_LAT)) begin
            wd_next = wd + WD_W'(1);
        end
    end

    // Fault detection; timeout fires only on the transition into MAX_LAT
    always_comb begin
        err_set                = '0;
        err_set[ERR_ISSUE_OVF] = issue_nd && tag_full && !core_rdy;
        err_set[ERR_ORPHAN]    = core_rdy && tag_empty;
        err_set[ERR_RES_OVF]   = res_push && res_full && !res_pop;
        err_set[ERR_TIMEOUT]   = (wd != WD_W'(MAX_LAT)) && (wd_next == WD_W'(MAX_LAT));
    end

    // Watchdog and sticky flags; a new fault outranks clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            wd  <= '0;
            err <= '0;
        end else begin
            wd  <= wd_next;
            err <= err_set | (err & ~{ERR_N{clr_err}});
        end
    end

    assign can_issue           = !tag_full;
    assign out_valid           = !res_empty;
    assign {out_tag, out_data} = res_head;
    assign issue_ovf           = err[ERR_ISSUE_OVF];
    assign orphan_err          = err[ERR_ORPHAN];
    assign res_ovf             = err[ERR_RES_OVF];
    assign timeout_err         = err[ERR_TIMEOUT];

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fp_result_collector;
    import fp_collect_pkg::*;

    localparam int DEPTH   = 8;
    localparam int MAX_LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_nd = 1'b0;
    logic [3:0]  issue_tag = '0;
    logic        can_issue;
    logic        core_rdy = 1'b0;
    logic [31:0] core_result = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_ready = 1'b0;
    logic [3:0]  in_flight;
    logic        clr_err = 1'b0;
    logic        issue_ovf;
    logic        orphan_err;
    logic        res_ovf;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] tq[$];
    entry_t     rq[$];
    bit         m_iovf, m_orph, m_rovf, m_to;
    int         m_age;

    fp_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .issue_nd    (issue_nd),
        .issue_tag   (issue_tag),
        .can_issue   (can_issue),
        .core_rdy    (core_rdy),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_ready   (out_ready),
        .in_flight   (in_flight),
        .clr_err     (clr_err),
        .issue_ovf   (issue_ovf),
        .orphan_err  (orphan_err),
        .res_ovf     (res_ovf),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs
    task automatic model(input bit r, input bit iss, input logic [3:0] tg, input bit rdy,
                         input logic [31:0] res, input bit ordy, input bit clr);
        bit         t_empty, t_full, r_pop, r_full, got;
        bit         s_iovf, s_orph, s_rovf, s_to;
        logic [3:0] t;
        int         nage;
        if (r) begin
            tq.delete();
            rq.delete();
            {m_iovf, m_orph, m_rovf, m_to} = '0;
            m_age = 0;
            return;
        end
        t_empty = (tq.size() == 0);
        t_full  = (tq.size() == DEPTH);
        r_pop   = (rq.size() > 0) && ordy;
        r_full  = (rq.size() == DEPTH);
        {s_iovf, s_orph, s_rovf, s_to} = '0;
        got = 1'b0;
        t   = '0;
        if (rdy) begin
            if (t_empty) s_orph = 1'b1;
            else begin
                t   = tq.pop_front();
                got = 1'b1;
            end
        end
        if (iss) begin
            if (t_full && !rdy) s_iovf = 1'b1;
            else tq.push_back(tg);
        end
        if (r_pop) void'(rq.pop_front());
        if (got) begin
            if (r_full && !r_pop) s_rovf = 1'b1;
            else rq.push_back('{tag: t, data: res});
        end
        // Age of the oldest outstanding issue, capped at MAX_LAT
        if (got || t_empty) nage = 0;
        else nage = (m_age + 1 > MAX_LAT) ? MAX_LAT : m_age + 1;
        s_to  = (m_age < MAX_LAT) && (nage == MAX_LAT);
        m_age = nage;
        m_iovf = s_iovf || (m_iovf && !clr);
        m_orph = s_orph || (m_orph && !clr);
        m_rovf = s_rovf || (m_rovf && !clr);
        m_to   = s_to   || (m_to   && !clr);
    endtask

    // Drive one cycle, update model, then compare every output after the edge
    task automatic step(input bit r, input bit iss, input logic [3:0] tg, input bit rdy,
                        input logic [31:0] res, input bit ordy, input bit clr);
        rst         = r;
        issue_nd    = iss;
        issue_tag   = tg;
        core_rdy    = rdy;
        core_result = res;
        out_ready   = ordy;
        clr_err     = clr;
        model(r, iss, tg, rdy, res, ordy, clr);
        @(posedge clk);
        #1;
        chk("in_flight",   64'(in_flight),   64'(tq.size()));
        chk("can_issue",   64'(can_issue),   64'(tq.size() < DEPTH));
        chk("out_valid",   64'(out_valid),   64'(rq.size() > 0));
        chk("out_data",    64'(out_data),    (rq.size() > 0) ? 64'(rq[0].data) : 64'd0);
        chk("out_tag",     64'(out_tag),     (rq.size() > 0) ? 64'(rq[0].tag) : 64'd0);
        chk("issue_ovf",   64'(issue_ovf),   64'(m_iovf));
        chk("orphan_err",  64'(orphan_err),  64'(m_orph));
        chk("res_ovf",     64'(res_ovf),     64'(m_rovf));
        chk("timeout_err", 64'(timeout_err), 64'(m_to));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 32'd0, 0, 0);
    endtask

    initial begin
        int p_iss, p_rdy, p_ordy;

        // Reset state
        step(1, 0, 4'd0, 0, 32'd0, 0, 0);
        step(1, 0, 4'd0, 0, 32'd0, 0, 0);
        chk("rst_can_issue", 64'(can_issue), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // Single op: rdy four cycles after issue
        step(0, 1, 4'd3, 0, 32'd0, 0, 0);
        idle(3);
        step(0, 0, 4'd0, 1, 32'h40490FDB, 0, 0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_tag",   64'(out_tag),   64'd3);
        chk("single_data",  64'(out_data),  64'h40490FDB);
        step(0, 0, 4'd0, 0, 32'd0, 1, 0);
        chk("single_drained", 64'(out_valid), 64'd0);
        chk("single_inflight", 64'(in_flight), 64'd0);

        // Burst of 8 issues, 9th overflows, then ordered drain
        for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 0, 32'd0, 0, 0);
        chk("burst_full", 64'(can_issue), 64'd0);
        step(0, 1, 4'd8, 0, 32'd0, 0, 0);
        chk("burst_ovf", 64'(issue_ovf), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 4'd0, 1, $urandom, 1, 0);
            chk("burst_order", 64'(out_tag), 64'(i));
        end
        step(0, 0, 4'd0, 0, 32'd0, 1, 1);

        // Full tag FIFO with simultaneous issue and rdy
        for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 0, 32'd0, 0, 0);
        step(0, 1, 4'd9, 1, $urandom, 1, 0);
        chk("simul_no_ovf",   64'(issue_ovf), 64'd0);
        chk("simul_inflight", 64'(in_flight), 64'd8);
        for (int i = 0; i < 8; i++) step(0, 0, 4'd0, 1, $urandom, 1, 0);
        chk("simul_newest", 64'(out_tag), 64'd9);
        step(0, 0, 4'd0, 0, 32'd0, 1, 0);

        // Orphan rdy
        step(0, 0, 4'd0, 1, 32'hDEADBEEF, 0, 0);
        chk("orphan_flag",  64'(orphan_err), 64'd1);
        chk("orphan_valid", 64'(out_valid),  64'd0);
        step(0, 0, 4'd0, 0, 32'd0, 0, 1);

        // Backpressure: nine completions with out_ready low
        for (int k = 0; k < 10; k++)
            step(0, k < 9, 4'(k), k >= 1, 32'h1000 + 32'(k), 0, 0);
        chk("bp_ovf", 64'(res_ovf), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk("bp_retained", 64'(out_tag), 64'(k));
            step(0, 0, 4'd0, 0, 32'd0, 1, 0);
        end
        chk("bp_empty", 64'(out_valid), 64'd0);
        step(0, 0, 4'd0, 0, 32'd0, 0, 1);
        chk("clr_flags", 64'({issue_ovf, orphan_err, res_ovf, timeout_err}), 64'd0);

        // Timeout after MAX_LAT cycles, late rdy still delivers
        step(0, 1, 4'd5, 0, 32'd0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            step(0, 0, 4'd0, 0, 32'd0, 0, 0);
            if (c == 15) chk("timeout_early", 64'(timeout_err), 64'd0);
        end
        chk("timeout_set", 64'(timeout_err), 64'd1);
        step(0, 0, 4'd0, 1, 32'h3F800000, 0, 0);
        chk("late_tag", 64'(out_tag), 64'd5);
        step(0, 0, 4'd0, 0, 32'd0, 1, 1);

        // Reset mid-burst discards everything; following rdy is an orphan
        for (int i = 1; i <= 5; i++) step(0, 1, 4'(i), 0, 32'd0, 0, 0);
        step(0, 0, 4'd0, 1, 32'hA, 0, 0);
        step(0, 0, 4'd0, 1, 32'hB, 0, 0);
        step(1, 0, 4'd0, 0, 32'd0, 0, 0);
        chk("rst_mid_inflight", 64'(in_flight), 64'd0);
        chk("rst_mid_valid",    64'(out_valid), 64'd0);
        step(0, 0, 4'd0, 1, 32'hC, 0, 0);
        chk("rst_mid_orphan", 64'(orphan_err), 64'd1);

        // Randomized traffic with per-phase rate mixes
        step(1, 0, 4'd0, 0, 32'd0, 0, 0);
        for (int ph = 0; ph < 8; ph++) begin
            p_iss  = $urandom_range(20, 90);
            p_rdy  = $urandom_range(20, 90);
            p_ordy = $urandom_range(10, 100);
            for (int c = 0; c < 80; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < p_iss,
                     4'($urandom_range(0, 15)),
                     $urandom_range(0, 99) < p_rdy,
                     $urandom,
                     $urandom_range(0, 99) < p_ordy,
                     $urandom_range(0, 29) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Receiving end of the float-core handshake: consumes the core's result/rdy stream and pairs each result with the destination tag recorded when the matching operation_nd pulse was issued.
- Sits between the floating-point arithmetic cores and the FFT datapath controller.
- Buffers tagged results behind a valid/ready output, since the core cannot be stalled.
- Flags protocol faults: orphan rdy, dropped issue, dropped result, latency timeout.

Parameters:
DATA_W, 32, result width (IEEE-754 single)
TAG_W, 4, destination tag width (butterfly/RAM slot index)
DEPTH, 8, entries in the tag FIFO and in the result FIFO (power of 2)
MAX_LAT, 16, cycles the oldest outstanding issue may wait for rdy before timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
issue_nd  in  1  one-cycle pulse, same cycle the core sees operation_nd
issue_tag  in  TAG_W  tag for this issue
can_issue  out  1  tag FIFO not full (combinational from count)
core_rdy  in  1  core result strobe
core_result  in  DATA_W  core result, valid when core_rdy=1
out_valid  out  1  result FIFO non-empty
out_data  out  DATA_W  head result
out_tag  out  TAG_W  head tag
out_ready  in  1  consumer accepts head when out_valid=1
in_flight  out  $clog2(DEPTH)+1  outstanding issues (tag FIFO count)
clr_err  in  1  clears sticky error flags
issue_ovf  out  1  sticky: issue dropped, tag FIFO full
orphan_err  out  1  sticky: core_rdy with no outstanding issue
res_ovf  out  1  sticky: result dropped, result FIFO full
timeout_err  out  1  sticky: oldest issue waited MAX_LAT cycles

Behaviour:
- Reset: both FIFOs empty, pointers 0, in_flight=0, out_valid=0, out_data=0, out_tag=0, all error flags 0, watchdog 0, can_issue=1.
- Reset mid-operation discards all buffered tags and results. Core results arriving after reset count as orphans.
- Tag FIFO:
  - Push on issue_nd; pop on core_rdy.
  - When full, issue_nd and core_rdy in the same cycle is legal: count unchanged, head advances.
  - Full, issue_nd, no core_rdy: tag dropped, issue_ovf<=1.
- core_rdy handling:
  - Tag FIFO empty: no pop, no result push, orphan_err<=1.
  - Same-cycle issue_nd into an empty FIFO is not matched to that rdy: the core has at least 1-cycle latency.
  - Otherwise push {head tag, core_result} into the result FIFO.
- Result FIFO:
  - First-word-fall-through; out_data/out_tag are driven from registered storage at the read pointer.
  - Pop when out_valid && out_ready.
  - When full, a push with a pop in the same cycle is legal.
  - Full with push and no pop: result dropped, res_ovf<=1. The tag is still consumed.
- Latency: core_rdy at cycle t makes out_valid=1 at t+1 if the result FIFO was empty. Min rdy-to-consume latency is 1 cycle.
- Watchdog:
  - Holds 0 while the tag FIFO is empty; clears to 0 on every tag pop.
  - Otherwise increments, saturating at MAX_LAT.
  - Reaching MAX_LAT sets timeout_err<=1.
- Error flags: clr_err clears all four. A fault in the same cycle as clr_err wins (flag set). Flags are unaffected by FIFO activity otherwise.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count is held separately and is full at DEPTH.
- Results leave in issue order. The core is in-order; no reordering is performed.

Decomposition:
- Package fp_collect_pkg: DATA_W/TAG_W defaults, entry struct {tag, data}, error-flag index constants.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head). Instantiated twice: tag FIFO (TAG_W) and result FIFO (TAG_W+DATA_W).
- Top contains the watchdog, error logic and glue only.

Test Plan:
- Single op: issue_nd tag=3, core_rdy 4 cycles later with 0x40490FDB -> next cycle out_valid=1, out_tag=3, out_data=0x40490FDB; out_ready pulse -> out_valid=0, in_flight=0.
- Burst: 8 back-to-back issues tags 0..7 (can_issue falls after the 8th), 9th issue -> issue_ovf=1. Then rdy x8 with out_ready=1 -> tags 0..7 out in order.
- Full simultaneous: tag FIFO full, issue_nd tag=9 and core_rdy same cycle -> no issue_ovf, in_flight stays 8, tag 9 becomes newest.
- Orphan and backpressure:
  - core_rdy with empty tag FIFO -> orphan_err=1, out_valid stays 0.
  - Hold out_ready=0 through 9 completions -> res_ovf=1, 8 results retained.
  - clr_err -> flags 0.
- Timeout: issue tag=5, no rdy for 16 cycles -> timeout_err=1 on cycle 16. Late rdy still delivers tag 5.
- Reset mid-burst: 3 outstanding, 2 buffered, rst for 1 cycle -> in_flight=0, out_valid=0. Following core_rdy -> orphan_err=1.
